// File: rtl/iob_ibus_prefetch.sv
// iob_ibus_prefetch: read-only instruction prefetch buffer.
// Keeps a small FIFO of sequential words in front of the CPU fetch port.
// Non-sequential fetches and flushes drop both buffered and in-flight data
// and restart the stream from the new address.
module iob_ibus_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              flush_i,
  input  logic              cpu_avalid_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic              mem_avalid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Buffered words with their byte address; storage needs no reset.
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Address of every accepted request, consumed in order by the responses.
  logic [ADDR_W-1:0] r_tag [DEPTH];
  logic [PTR_W-1:0]  r_tag_wr;
  logic [PTR_W-1:0]  r_tag_rd;

  logic [CNT_W-1:0]  r_outst;
  logic [CNT_W-1:0]  r_discard;
  logic [ADDR_W-1:0] r_next_addr;
  // Address of the word the stream delivers next (FIFO head when non-empty).
  logic [ADDR_W-1:0] r_exp_addr;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic              w_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic [CNT_W:0]    w_occ;
  logic              w_mem_acc;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_hit;
  logic              w_redirect;
  logic              w_clear;
  logic [CNT_W-1:0]  w_outst_nxt;

  assign w_empty      = (r_count == CNT_W'(0));
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_occ        = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_outst);
  assign mem_avalid_o = (r_state == ST_STREAM) & (w_occ < (CNT_W+1)'(DEPTH)) & ~flush_i;
  assign mem_addr_o   = r_next_addr;
  assign w_mem_acc    = mem_avalid_o & mem_ready_i;
  // Responses with nothing outstanding (e.g. after reset) are ignored.
  assign w_rsp        = mem_rvalid_i & (r_outst != CNT_W'(0));
  assign w_drop       = w_rsp & (r_discard != CNT_W'(0));
  assign w_push       = w_rsp & ~w_drop;
  assign w_outst_nxt  = r_outst + CNT_W'(w_mem_acc) - CNT_W'(w_rsp);
  assign w_clear      = flush_i | w_redirect;
  assign cpu_ready_o  = w_hit;
  assign cpu_rvalid_o = r_rvalid;
  assign cpu_rdata_o  = r_rdata;

  // Next-state and hit/miss decision; flush overrides any CPU request.
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_redirect  = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_avalid_i) begin
            w_redirect  = 1'b1;
            w_state_nxt = ST_STREAM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (cpu_avalid_i) begin
            if (!w_empty && (w_head_addr == cpu_addr_i)) begin
              w_hit = 1'b1;
            end else if (w_empty && (cpu_addr_i == r_exp_addr)) begin
              w_hit = 1'b0;
            end else begin
              w_redirect = 1'b1;
            end
          end else begin
            w_hit = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointers, counters and the registered CPU response.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= PTR_W'(0);
      r_rd_ptr    <= PTR_W'(0);
      r_count     <= CNT_W'(0);
      r_tag_wr    <= PTR_W'(0);
      r_tag_rd    <= PTR_W'(0);
      r_outst     <= CNT_W'(0);
      r_discard   <= CNT_W'(0);
      r_next_addr <= ADDR_W'(0);
      r_exp_addr  <= ADDR_W'(0);
      r_rvalid    <= 1'b0;
      r_rdata     <= DATA_W'(0);
    end else if (cke_i) begin
      r_state  <= w_state_nxt;
      r_outst  <= w_outst_nxt;
      r_rvalid <= w_hit;
      if (w_hit) begin
        r_rdata <= r_fifo_data[r_rd_ptr];
      end
      if (w_mem_acc) begin
        r_tag_wr <= r_tag_wr + PTR_W'(1);
      end
      if (w_rsp) begin
        r_tag_rd <= r_tag_rd + PTR_W'(1);
      end
      // Everything still in flight after a restart belongs to the old stream.
      if (w_clear) begin
        r_discard <= w_outst_nxt;
      end else if (w_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
      if (w_clear) begin
        r_wr_ptr <= PTR_W'(0);
        r_rd_ptr <= PTR_W'(0);
        r_count  <= CNT_W'(0);
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_hit) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_hit);
      end
      if (w_redirect) begin
        r_next_addr <= cpu_addr_i;
        r_exp_addr  <= cpu_addr_i;
      end else begin
        if (w_mem_acc) begin
          r_next_addr <= r_next_addr + STRIDE;
        end
        if (w_hit) begin
          r_exp_addr <= r_exp_addr + STRIDE;
        end
      end
    end
  end

  // FIFO and tag storage writes.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (w_mem_acc) begin
        r_tag[r_tag_wr] <= mem_addr_o;
      end
      if (w_push && !w_clear) begin
        r_fifo_addr[r_wr_ptr] <= r_tag[r_tag_rd];
        r_fifo_data[r_wr_ptr] <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_iob_ibus_prefetch.sv
// Bench for iob_ibus_prefetch: a CPU fetch driver, an in-order memory model
// with configurable latency/backpressure, and a scoreboard of fetched words.
module tb_iob_ibus_prefetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk_i = 1'b0;
  logic              arst_i;
  logic              cke_i;
  logic              flush_i;
  logic              cpu_avalid_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic              cpu_ready_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_rvalid_o;
  logic              mem_avalid_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;

  iob_ibus_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .flush_i(flush_i),
    .cpu_avalid_i(cpu_avalid_i), .cpu_addr_i(cpu_addr_i), .cpu_ready_o(cpu_ready_o),
    .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
    .mem_avalid_o(mem_avalid_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] cpu_q[$];
  logic [31:0] sb[$];
  logic [31:0] mem_log[$];
  int          cyc;
  int          n_chk;
  int          n_fail;
  int          n_rv;
  int          lat_min;
  int          lat_max;
  bit          rand_ready;
  bit          last_acc_c;

  // Memory contents: word at byte address a holds its word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Drive CPU and memory inputs for the current cycle and let outputs settle.
  task automatic drive_settle();
    cpu_avalid_i = (cpu_q.size() > 0);
    cpu_addr_i   = (cpu_q.size() > 0) ? cpu_q[0] : 32'h0;
    mem_ready_i  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  // Record handshakes, clock once, then check the CPU response against the scoreboard.
  task automatic clock_check();
    logic        acc_m, acc_c, rsp, ck;
    logic [31:0] a_m, a_c, exp_d;
    int          lat;
    ck    = cke_i;
    acc_m = mem_avalid_o & mem_ready_i & ck;
    a_m   = mem_addr_o;
    acc_c = cpu_ready_o & cpu_avalid_i & ck;
    a_c   = cpu_addr_i;
    rsp   = mem_rvalid_i & ck;
    @(posedge clk_i);
    #1;
    last_acc_c = acc_c;
    if (ck) begin
      if (rsp) void'(pend.pop_front());
      if (acc_m) begin
        lat = $urandom_range(lat_min, lat_max);
        pend.push_back('{addr: a_m, rdy: cyc + lat});
        mem_log.push_back(a_m);
      end
      if (acc_c) begin
        void'(cpu_q.pop_front());
        sb.push_back(mem_word(a_c));
      end
      cyc++;
      n_chk++;
      if (cpu_rvalid_o !== acc_c) begin
        n_fail++;
        $display("FAIL rvalid_timing: got %b want %b at cycle %0d", cpu_rvalid_o, acc_c, cyc);
      end
      if (cpu_rvalid_o === 1'b1) begin
        n_rv++;
        if (sb.size() > 0) begin
          exp_d = sb.pop_front();
          n_chk++;
          if (cpu_rdata_o !== exp_d) begin
            n_fail++;
            $display("FAIL rdata: got %h want %h at cycle %0d", cpu_rdata_o, exp_d, cyc);
          end
        end
      end
    end
  endtask

  // Run until every queued fetch has been accepted or the budget runs out.
  task automatic run_fetches(input int budget, input string name);
    int t;
    t = 0;
    while (cpu_q.size() > 0 && t < budget) begin
      drive_settle();
      clock_check();
      t++;
    end
    n_chk++;
    if (cpu_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d fetches left, want 0", name, cpu_q.size());
      cpu_q.delete();
    end
  endtask

  // One flush cycle to start each scenario from IDLE.
  task automatic restart();
    flush_i = 1'b1;
    drive_settle();
    clock_check();
    flush_i = 1'b0;
    mem_log.delete();
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    cpu_q.push_back(32'h40);
    drive_settle();
    n_chk += 5;
    if (cpu_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cpu_ready_o); end
    if (cpu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid_o); end
    if (cpu_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata_o); end
    if (mem_avalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_avalid: got %b want 0", mem_avalid_o); end
    if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    clock_check();
    arst_i = 1'b0;
    cpu_q.delete();
  endtask

  task automatic test_sequential();
    int first, last;
    restart();
    for (int i = 0; i < 8; i++) cpu_q.push_back(32'(i * 4));
    first = -1;
    last  = -1;
    for (int t = 0; t < 40 && cpu_q.size() > 0; t++) begin
      drive_settle();
      clock_check();
      if (last_acc_c) begin
        if (first < 0) first = t;
        last = t;
      end
    end
    n_chk += 2;
    if (first != 3) begin n_fail++; $display("FAIL seq_first_ready: got cycle %0d want 3", first); end
    if (last != 10) begin n_fail++; $display("FAIL seq_last_ready: got cycle %0d want 10", last); end
  endtask

  task automatic test_jump();
    int rv0;
    lat_min = 3;
    lat_max = 3;
    restart();
    rv0 = n_rv;
    cpu_q = '{32'h10, 32'h14, 32'h18, 32'h100, 32'h104, 32'h108};
    run_fetches(100, "jump");
    n_chk++;
    if (n_rv - rv0 != 6) begin n_fail++; $display("FAIL jump_deliveries: got %0d want 6", n_rv - rv0); end
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_flush();
    int acc_t;
    restart();
    cpu_q.push_back(32'h200);
    run_fetches(20, "flush_pre");
    for (int i = 0; i < 6; i++) begin
      drive_settle();
      clock_check();
    end
    flush_i = 1'b1;
    cpu_q.push_back(32'h204);
    drive_settle();
    n_chk += 2;
    if (cpu_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", cpu_ready_o); end
    if (mem_avalid_o !== 1'b0) begin n_fail++; $display("FAIL flush_mem_avalid: got %b want 0", mem_avalid_o); end
    clock_check();
    flush_i = 1'b0;
    acc_t = -1;
    for (int t = 1; t < 20 && acc_t < 0; t++) begin
      drive_settle();
      clock_check();
      if (last_acc_c) acc_t = t;
    end
    n_chk++;
    if (acc_t != 4) begin n_fail++; $display("FAIL flush_refetch: got cycle %0d want 4", acc_t); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    restart();
    cpu_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    run_fetches(40, "wrap");
    n_chk++;
    if (mem_log.size() < 3) begin
      n_fail++;
      $display("FAIL wrap_req_count: got %0d want >= 3", mem_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (mem_log[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d: got %h want %h", i, mem_log[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int t;
    lat_min    = 1;
    lat_max    = 3;
    rand_ready = 1'b1;
    restart();
    for (int i = 0; i < 40; i++) cpu_q.push_back(32'h400 + 32'(i * 4));
    t = 0;
    while (cpu_q.size() > 0 && t < 800) begin
      drive_settle();
      clock_check();
      n_chk++;
      if (pend.size() > DEPTH) begin
        n_fail++;
        $display("FAIL random_inflight: got %0d want <= %0d", pend.size(), DEPTH);
      end
      t++;
    end
    n_chk++;
    if (cpu_q.size() != 0) begin n_fail++; $display("FAIL random_timeout: %0d left want 0", cpu_q.size()); cpu_q.delete(); end
    lat_max    = 1;
    rand_ready = 1'b0;
  endtask

  task automatic test_cke();
    logic        s_ready, s_rvalid, s_mavalid;
    logic [31:0] s_rdata, s_maddr;
    restart();
    for (int i = 0; i < 12; i++) cpu_q.push_back(32'h600 + 32'(i * 4));
    for (int i = 0; i < 5; i++) begin
      drive_settle();
      clock_check();
    end
    cke_i = 1'b0;
    drive_settle();
    s_ready   = cpu_ready_o;
    s_rvalid  = cpu_rvalid_o;
    s_rdata   = cpu_rdata_o;
    s_mavalid = mem_avalid_o;
    s_maddr   = mem_addr_o;
    clock_check();
    for (int i = 0; i < 4; i++) begin
      drive_settle();
      n_chk += 5;
      if (cpu_ready_o !== s_ready) begin n_fail++; $display("FAIL cke_ready: got %b want %b", cpu_ready_o, s_ready); end
      if (cpu_rvalid_o !== s_rvalid) begin n_fail++; $display("FAIL cke_rvalid: got %b want %b", cpu_rvalid_o, s_rvalid); end
      if (cpu_rdata_o !== s_rdata) begin n_fail++; $display("FAIL cke_rdata: got %h want %h", cpu_rdata_o, s_rdata); end
      if (mem_avalid_o !== s_mavalid) begin n_fail++; $display("FAIL cke_mem_avalid: got %b want %b", mem_avalid_o, s_mavalid); end
      if (mem_addr_o !== s_maddr) begin n_fail++; $display("FAIL cke_mem_addr: got %h want %h", mem_addr_o, s_maddr); end
      clock_check();
    end
    cke_i = 1'b1;
    run_fetches(60, "cke_resume");
  endtask

  initial begin
    arst_i       = 1'b1;
    cke_i        = 1'b1;
    flush_i      = 1'b0;
    cpu_avalid_i = 1'b0;
    cpu_addr_i   = 32'h0;
    mem_ready_i  = 1'b1;
    mem_rdata_i  = 32'h0;
    mem_rvalid_i = 1'b0;
    lat_min      = 1;
    lat_max      = 1;
    rand_ready   = 1'b0;
    cyc          = 0;
    n_chk        = 0;
    n_fail       = 0;
    n_rv         = 0;
    last_acc_c   = 1'b0;
    test_reset();
    test_sequential();
    test_jump();
    test_flush();
    test_wrap();
    test_random();
    test_cke();
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
